// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_RESP = 2'd1,
        ARB_DM_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_SRC__IF = 1'b0,
        ARB_SRC__DM = 1'b1
    } arb_src_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed DM-first priority with an IF starvation counter that forces an IF win
// after STARVE_LIMIT consecutive lost arbitrations.
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     if_req,
    input  logic     dm_req,
    input  logic     arb_en,
    output arb_src_t winner,
    output logic     winner_valid
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       force_if;

    always_comb begin
        force_if     = if_req && (starve_cnt == LIMIT);
        winner       = (dm_req && !force_if) ? ARB_SRC__DM : ARB_SRC__IF;
        winner_valid = arb_en && (if_req || dm_req);
    end

    // Count only while IF keeps asking; any gap in if_req forgives the debt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= 4'd0;
        end else if (!if_req) begin
            starve_cnt <= 4'd0;
        end else if (winner_valid) begin
            if (winner == ARB_SRC__IF)
                starve_cnt <= 4'd0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Optional perf counters: define MEM_ARBITER_PERF_CNT_EN.
//
//   state       | meaning
//   ARB_IDLE    | arbitrate; grant and memory request issued combinationally
//   ARB_IF_RESP | memory returns IF read data, if_rvalid pulse
//   ARB_DM_RESP | memory returns DM load data / store ack, dm_rvalid pulse
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = $bits(addr_t),
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARBITER_PERF_CNT_EN
    ,
    output logic [31:0]       if_stall_cnt,
    output logic [31:0]       dm_access_cnt
`endif
);

    arb_state_t state;
    arb_src_t   winner;
    logic       winner_valid;
    logic       arb_en;
    logic       dm_we_q;

    // Gating with reset keeps every output at zero while reset is held.
    assign arb_en = reset && (state == ARB_IDLE);

    mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .dm_req       (dm_req),
        .arb_en       (arb_en),
        .winner       (winner),
        .winner_valid (winner_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ARB_IDLE;
            dm_we_q <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (winner_valid) begin
                        if (winner == ARB_SRC__DM) begin
                            state   <= ARB_DM_RESP;
                            dm_we_q <= dm_we;
                        end else begin
                            state <= ARB_IF_RESP;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (reset) begin
            case (state)
                ARB_IDLE: begin
                    if (winner_valid && winner == ARB_SRC__DM) begin
                        dm_gnt    = 1'b1;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        mem_we    = dm_we;
                    end else if (winner_valid) begin
                        if_gnt   = 1'b1;
                        mem_addr = if_addr;
                    end
                end
                ARB_IF_RESP: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                ARB_DM_RESP: begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = dm_we_q ? '0 : mem_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARBITER_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_stall_cnt  <= 32'd0;
            dm_access_cnt <= 32'd0;
        end else begin
            if (if_req && !if_gnt && if_stall_cnt != 32'hFFFF_FFFF)
                if_stall_cnt <= if_stall_cnt + 32'd1;
            if (dm_gnt && dm_access_cnt != 32'hFFFF_FFFF)
                dm_access_cnt <= dm_access_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
`ifdef MEM_ARBITER_PERF_CNT_EN
    logic [31:0] if_stall_cnt;
    logic [31:0] dm_access_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARBITER_PERF_CNT_EN
        ,
        .if_stall_cnt  (if_stall_cnt),
        .dm_access_cnt (dm_access_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs change.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4; dm_wdata = 32'h5;
        mem_rdata = 32'h0;
        @(negedge clk);
        check_val("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check_val("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        cyc();
        reset = 1'b1;

        // IF only read
        cyc();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check_val("if_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("if_mem_addr", mem_addr, 32'h10);
        check_val("if_mem_we", {31'd0, mem_we}, 32'd0);
        cyc();
        if_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_val("if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_val("if_rdata", if_rdata, 32'hDEADBEEF);
        check_val("if_resp_nognt", {30'd0, if_gnt, dm_gnt}, 32'd0);
        cyc();
        @(negedge clk);
        check_val("if_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

        // DM store
        cyc();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
        @(negedge clk);
        check_val("st_gnt", {31'd0, dm_gnt}, 32'd1);
        check_val("st_mem_we", {31'd0, mem_we}, 32'd1);
        check_val("st_mem_addr", mem_addr, 32'h200);
        check_val("st_mem_wdata", mem_wdata, 32'h12345678);
        cyc();
        dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'hAAAA5555;
        @(negedge clk);
        check_val("st_rvalid", {31'd0, dm_rvalid}, 32'd1);
        check_val("st_rdata", dm_rdata, 32'd0);

        // DM load
        cyc();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        @(negedge clk);
        check_val("ld_gnt", {31'd0, dm_gnt}, 32'd1);
        check_val("ld_mem_we", {31'd0, mem_we}, 32'd0);
        check_val("ld_mem_addr", mem_addr, 32'h300);
        cyc();
        dm_req = 1'b0; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check_val("ld_rvalid", {31'd0, dm_rvalid}, 32'd1);
        check_val("ld_rdata", dm_rdata, 32'hCAFEF00D);
        cyc();

        // Contention: DM at 0,2,4,6; forced IF at 8; DM at 10
        if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h88;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            check_val($sformatf("cont_dm_gnt_c%0d", c), {31'd0, dm_gnt},
                      (c % 2 == 0 && c != 8) ? 32'd1 : 32'd0);
            check_val($sformatf("cont_if_gnt_c%0d", c), {31'd0, if_gnt},
                      (c == 8) ? 32'd1 : 32'd0);
            if (c == 9)
                check_val("cont_starve_clr", {28'd0, u_dut.u_prio.starve_cnt}, 32'd0);
            cyc();
        end
        if_req = 1'b0; dm_req = 1'b0;
        cyc();

        // if_req dropped in response cycles: starvation never builds up
        dm_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if_req = (c % 2 == 0);
            @(negedge clk);
            if (c % 2 == 0) begin
                check_val($sformatf("tog_dm_gnt_c%0d", c), {31'd0, dm_gnt}, 32'd1);
                check_val($sformatf("tog_if_gnt_c%0d", c), {31'd0, if_gnt}, 32'd0);
            end
            cyc();
        end
        if_req = 1'b0; dm_req = 1'b0;
        cyc();

        // Reset during a store grant: mem_we drops immediately
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'h77;
        #1;
        check_val("rg_mem_we_pre", {31'd0, mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        check_val("rg_mem_we_rst", {31'd0, mem_we}, 32'd0);
        check_val("rg_dm_gnt_rst", {31'd0, dm_gnt}, 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        // Reset in the cycle after a DM load grant: response dropped
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        @(negedge clk);
        check_val("rl_gnt", {31'd0, dm_gnt}, 32'd1);
        cyc();
        dm_req = 1'b0; mem_rdata = 32'h13579BDF;
        #1;
        reset = 1'b0;
        #1;
        check_val("rl_rvalid", {31'd0, dm_rvalid}, 32'd0);
        check_val("rl_rdata", dm_rdata, 32'd0);
        check_val("rl_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        check_val("rl_rvalid_held", {31'd0, dm_rvalid}, 32'd0);
        cyc();
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        check_val("rl_post_if_gnt", {31'd0, if_gnt}, 32'd1);
        check_val("rl_post_mem_addr", mem_addr, 32'h80);
        cyc();
        if_req = 1'b0;
        @(negedge clk);
        check_val("rl_post_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        cyc();

`ifdef MEM_ARBITER_PERF_CNT_EN
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check_val("perf_stall_rst", if_stall_cnt, 32'd0);
        check_val("perf_dm_rst", dm_access_cnt, 32'd0);
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 9) if_req = 1'b0;
            cyc();
        end
        @(negedge clk);
        check_val("perf_if_stall", if_stall_cnt, 32'd8);
        check_val("perf_dm_access", dm_access_cnt, 32'd4);
        if_req = 1'b0; dm_req = 1'b0;
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
